// File: rtl/cjmcu1401_pkg.sv
// Shared definitions for the CJMCU-1401 (TSL1401) sensor driver and line capture.
// Keeping the pixel count and ADC width here keeps the driver and capture matched.
package cjmcu1401_pkg;

  localparam int unsigned CJMCU_NUMBER_OF_PIXEL = 128;
  localparam int unsigned CJMCU_ADC_WIDTH       = 12;
  localparam int unsigned CJMCU_LINE_CNT_WIDTH  = 16;

  typedef enum logic {
    W_IDLE    = 1'b0,
    W_CAPTURE = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/cjmcu1401_line_capture_if.sv
// Pixel stream from the line capture toward the PS/DMA: valid/ready with last-pixel
// marking and the sequence number of the line in flight.
interface cjmcu1401_line_capture_if #(
  parameter int unsigned ADC_WIDTH      = 12,
  parameter int unsigned LINE_CNT_WIDTH = 16
);

  logic [ADC_WIDTH-1:0]      m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;
  logic [LINE_CNT_WIDTH-1:0] m_line_id;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output m_line_id,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    input  m_line_id,
    output m_ready
  );

endinterface

// File: rtl/cjmcu1401_line_ram.sv
// Ping-pong line storage: simple dual-port RAM addressed by {bank, pixel index},
// one write port and one read port with a single registered read stage.
module cjmcu1401_line_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cjmcu1401_line_capture.sv
// Captures one ADC word per sample trigger into a two-line ping-pong buffer and
// streams each completed line out in capture order while the next line fills.
module cjmcu1401_line_capture
  import cjmcu1401_pkg::*;
#(
  parameter int unsigned NUMBER_OF_PIXEL = CJMCU_NUMBER_OF_PIXEL,
  parameter int unsigned ADC_WIDTH       = CJMCU_ADC_WIDTH,
  parameter int unsigned LINE_CNT_WIDTH  = CJMCU_LINE_CNT_WIDTH
) (
  input  logic                      master_clock,
  input  logic                      master_reset,
  input  logic                      cjmcu1401_si,
  input  logic                      sample_capture_trigger,
  input  logic [ADC_WIDTH-1:0]      adc_data,
  cjmcu1401_line_capture_if.master  m_stream,
  output logic [LINE_CNT_WIDTH-1:0] line_drop_count,
  output logic [LINE_CNT_WIDTH-1:0] short_line_count
);

  localparam int unsigned IDX_W  = (NUMBER_OF_PIXEL > 1) ? $clog2(NUMBER_OF_PIXEL) : 1;
  localparam int unsigned ADDR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUMBER_OF_PIXEL - 1);
  localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
  localparam logic [LINE_CNT_WIDTH-1:0] CNT_ONE  = LINE_CNT_WIDTH'(1);
  localparam logic [LINE_CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic                      si_q, si_d;
  logic                      si_rise;

  wr_state_e                 wr_state_q, wr_state_d;
  logic                      wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]          widx_q, widx_d;
  logic [LINE_CNT_WIDTH-1:0] line_seq_q, line_seq_d;
  logic [LINE_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [LINE_CNT_WIDTH-1:0] short_q, short_d;
  logic [LINE_CNT_WIDTH-1:0] tag_q [2];
  logic [LINE_CNT_WIDTH-1:0] tag_d [2];
  logic [1:0]                full_q, full_d;
  logic                      full_set;
  logic                      full_clr;
  logic                      ram_we;

  rd_state_e                 rd_state_q, rd_state_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]          ridx_q, ridx_d;
  logic                      rd_done_q, rd_done_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]          s1_idx_q, s1_idx_d;
  logic                      out_valid_q, out_valid_d;
  logic [ADC_WIDTH-1:0]      out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic [LINE_CNT_WIDTH-1:0] out_id_q, out_id_d;
  logic                      rd_issue;
  logic                      out_ready;
  logic [ADC_WIDTH-1:0]      ram_rdata;

  assign si_d    = cjmcu1401_si;
  assign si_rise = cjmcu1401_si & ~si_q;

  cjmcu1401_line_ram #(
    .DATA_W (ADC_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_ram (
    .clk   (master_clock),
    .we    (ram_we),
    .waddr ({wr_bank_q, widx_q}),
    .wdata (adc_data),
    .re    (rd_issue),
    .raddr ({rd_bank_q, ridx_q}),
    .rdata (ram_rdata)
  );

  // Writer: an SI edge always wins over a coincident trigger.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    widx_d     = widx_q;
    line_seq_d = line_seq_q;
    drop_d     = drop_q;
    short_d    = short_q;
    tag_d      = tag_q;
    full_set   = 1'b0;
    ram_we     = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (si_rise) begin
          if (!full_q[wr_bank_q]) begin
            widx_d     = '0;
            wr_state_d = W_CAPTURE;
          end else if (drop_q != CNT_MAX) begin
            drop_d = drop_q + CNT_ONE;
          end
        end
      end
      W_CAPTURE: begin
        if (si_rise) begin
          widx_d = '0;
          if (short_q != CNT_MAX) begin
            short_d = short_q + CNT_ONE;
          end
        end else if (sample_capture_trigger) begin
          ram_we = 1'b1;
          widx_d = widx_q + IDX_ONE;
          if (widx_q == LAST_IDX) begin
            full_set          = 1'b1;
            tag_d[wr_bank_q]  = line_seq_q;
            line_seq_d        = line_seq_q + CNT_ONE;
            wr_bank_d         = ~wr_bank_q;
            widx_d            = '0;
            wr_state_d        = W_IDLE;
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Writer only ever fills an empty bank and the reader only drains a full one.
  always_comb begin
    full_d = full_q;
    if (full_set) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (full_clr) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Reader: RAM read stage (s1) feeding the output register, prefetching whenever
  // s1 is empty or about to move into the output register.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    ridx_d      = ridx_q;
    rd_done_d   = rd_done_q;
    s1_valid_d  = s1_valid_q;
    s1_idx_d    = s1_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    rd_issue    = 1'b0;
    full_clr    = 1'b0;
    out_ready   = ~out_valid_q | m_stream.m_ready;

    case (rd_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_issue   = 1'b1;
          rd_state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        rd_issue = ~rd_done_q & (~s1_valid_q | out_ready);
      end
      default: rd_state_d = R_IDLE;
    endcase

    if (rd_issue) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = ridx_q;
      ridx_d     = ridx_q + IDX_ONE;
      if (ridx_q == LAST_IDX) begin
        rd_done_d = 1'b1;
        ridx_d    = '0;
      end
    end else if (out_ready) begin
      s1_valid_d = 1'b0;
    end

    if (out_ready) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q & (s1_idx_q == LAST_IDX);
      if (s1_valid_q) begin
        out_data_d = ram_rdata;
        out_id_d   = tag_q[rd_bank_q];
      end
    end

    if ((rd_state_q == R_STREAM) && out_valid_q && m_stream.m_ready && out_last_q) begin
      full_clr   = 1'b1;
      rd_bank_d  = ~rd_bank_q;
      rd_done_d  = 1'b0;
      rd_state_d = R_IDLE;
    end
  end

  always_ff @(posedge master_clock) begin
    if (master_reset) begin
      si_q        <= 1'b0;
      wr_state_q  <= W_IDLE;
      wr_bank_q   <= 1'b0;
      widx_q      <= '0;
      line_seq_q  <= '0;
      drop_q      <= '0;
      short_q     <= '0;
      tag_q[0]    <= '0;
      tag_q[1]    <= '0;
      full_q      <= '0;
      rd_state_q  <= R_IDLE;
      rd_bank_q   <= 1'b0;
      ridx_q      <= '0;
      rd_done_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      si_q        <= si_d;
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      widx_q      <= widx_d;
      line_seq_q  <= line_seq_d;
      drop_q      <= drop_d;
      short_q     <= short_d;
      tag_q[0]    <= tag_d[0];
      tag_q[1]    <= tag_d[1];
      full_q      <= full_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      ridx_q      <= ridx_d;
      rd_done_q   <= rd_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
    end
  end

  assign m_stream.m_data    = out_data_q;
  assign m_stream.m_valid   = out_valid_q;
  assign m_stream.m_last    = out_last_q;
  assign m_stream.m_line_id = out_id_q;
  assign line_drop_count    = drop_q;
  assign short_line_count   = short_q;

endmodule

// File: tb/tb_cjmcu1401_line_capture.sv
// Self-checking bench for the line capture: directed scenarios plus randomized
// lines, checked against a queue-based model of captured and pending lines.
module tb_cjmcu1401_line_capture;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 16;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          si   = 1'b0;
  logic          trig = 1'b0;
  logic [AW-1:0] adc  = '0;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] short_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;
  int rdy_pct    = 100;

  cjmcu1401_line_capture_if #(.ADC_WIDTH(AW), .LINE_CNT_WIDTH(CW)) bus ();

  cjmcu1401_line_capture #(
    .NUMBER_OF_PIXEL (N),
    .ADC_WIDTH       (AW),
    .LINE_CNT_WIDTH  (CW)
  ) dut (
    .master_clock           (clk),
    .master_reset           (rst),
    .cjmcu1401_si           (si),
    .sample_capture_trigger (trig),
    .adc_data               (adc),
    .m_stream               (bus),
    .line_drop_count        (drop_cnt),
    .short_line_count       (short_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pixels of completed lines awaiting output, their ids, and the line in progress.
  logic [AW-1:0] exp_data [$];
  logic [CW-1:0] exp_id [$];
  logic [AW-1:0] cur_pix [$];
  bit            capturing = 1'b0;
  int            beat_idx  = 0;
  logic [CW-1:0] seq = '0, m_drop = '0, m_short = '0;
  bit            si_prev = 1'b0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] hold_data;
  logic          hold_last;
  logic [CW-1:0] hold_id;
  int            cyc = 0;
  int            done_cyc = 0;

  logic [AW-1:0] data_log [$];
  logic          last_log [$];
  logic [CW-1:0] id_log [$];
  int            hs_cyc_log [$];

  // Compare process: inputs and outputs are both settled at the falling edge.
  always @(negedge clk) begin
    cyc++;
    chk("line_drop_count", 64'(drop_cnt), 64'(m_drop));
    chk("short_line_count", 64'(short_cnt), 64'(m_short));
    chk("valid_without_line", 64'(bus.m_valid && exp_id.size() == 0), 64'(0));
    if (prev_stall) begin
      chk("stall_valid", 64'(bus.m_valid), 64'(1));
      chk("stall_data", 64'(bus.m_data), 64'(hold_data));
      chk("stall_last", 64'(bus.m_last), 64'(hold_last));
      chk("stall_line_id", 64'(bus.m_line_id), 64'(hold_id));
    end

    if (rst) begin
      capturing = 1'b0;
      cur_pix.delete();
      exp_data.delete();
      exp_id.delete();
      beat_idx   = 0;
      seq        = '0;
      m_drop     = '0;
      m_short    = '0;
      si_prev    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (si && !si_prev) begin
        if (capturing) begin
          cur_pix.delete();
          if (m_short != {CW{1'b1}}) m_short = m_short + 1'b1;
        end else if (exp_id.size() == 2) begin
          if (m_drop != {CW{1'b1}}) m_drop = m_drop + 1'b1;
        end else begin
          capturing = 1'b1;
          cur_pix.delete();
        end
      end else if (trig && capturing) begin
        cur_pix.push_back(adc);
        if (cur_pix.size() == N) begin
          foreach (cur_pix[i]) exp_data.push_back(cur_pix[i]);
          exp_id.push_back(seq);
          seq = seq + 1'b1;
          cur_pix.delete();
          capturing = 1'b0;
          done_cyc = cyc;
        end
      end

      if (bus.m_valid && bus.m_ready && exp_id.size() != 0) begin
        chk("beat_data", 64'(bus.m_data), 64'(exp_data[0]));
        chk("beat_last", 64'(bus.m_last), 64'(beat_idx == N - 1));
        chk("beat_line_id", 64'(bus.m_line_id), 64'(exp_id[0]));
        void'(exp_data.pop_front());
        data_log.push_back(bus.m_data);
        last_log.push_back(bus.m_last);
        id_log.push_back(bus.m_line_id);
        hs_cyc_log.push_back(cyc);
        if (beat_idx == N - 1) begin
          beat_idx = 0;
          void'(exp_id.pop_front());
        end else begin
          beat_idx++;
        end
      end

      prev_stall = bus.m_valid && !bus.m_ready;
      hold_data  = bus.m_data;
      hold_last  = bus.m_last;
      hold_id    = bus.m_line_id;
      si_prev    = si;
    end
  end

  task automatic drive(input logic s, input logic t, input logic [AW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    rst  = r;
    si   = s;
    trig = t;
    adc  = d;
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      2:       bus.m_ready = ~bus.m_ready;
      default: bus.m_ready = ($urandom_range(0, 99) < rdy_pct);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic clear_logs();
    data_log.delete();
    last_log.delete();
    id_log.delete();
    hs_cyc_log.delete();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("reset_m_valid", 64'(bus.m_valid), 64'(0));
    chk("reset_m_last", 64'(bus.m_last), 64'(0));
    chk("reset_m_data", 64'(bus.m_data), 64'(0));
    chk("reset_m_line_id", 64'(bus.m_line_id), 64'(0));
    chk("reset_drop", 64'(drop_cnt), 64'(0));
    chk("reset_short", 64'(short_cnt), 64'(0));
    clear_logs();
  endtask

  // One SI pulse followed by n triggers carrying base+i, with random idle gaps.
  task automatic send_line(input int base, input int n, input int gap_max);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle(1);
      drive(1'b0, 1'b1, AW'(base + i), 1'b0);
    end
  endtask

  task automatic rand_line(input int n, input int gap_max);
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) idle(1);
      drive(1'b0, 1'b1, AW'($urandom), 1'b0);
    end
  endtask

  // Literal expectations for one streamed line starting at log offset off.
  task automatic check_line(input string name, input int off, input int base, input int id);
    chk({name, "_beats"}, 64'(data_log.size() >= off + N), 64'(1));
    if (data_log.size() >= off + N) begin
      for (int i = 0; i < N; i++) begin
        chk({name, "_data"}, 64'(data_log[off + i]), 64'(base + i));
        chk({name, "_last"}, 64'(last_log[off + i]), 64'(i == N - 1));
        chk({name, "_id"}, 64'(id_log[off + i]), 64'(id));
      end
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;

    // 1: clean line with ready held high.
    do_reset();
    ready_mode = 1;
    send_line(12'h100, N, 0);
    idle(15);
    chk("t1_count", 64'(data_log.size()), 64'(N));
    check_line("t1", 0, 12'h100, 0);
    if (hs_cyc_log.size() == N) begin
      chk("t1_latency", 64'(hs_cyc_log[0] - done_cyc), 64'(3));
      chk("t1_gap_free", 64'(hs_cyc_log[N-1] - hs_cyc_log[0]), 64'(N - 1));
    end

    // 2: same line with ready toggling every cycle.
    do_reset();
    ready_mode = 2;
    send_line(12'h100, N, 0);
    idle(30);
    chk("t2_count", 64'(data_log.size()), 64'(N));
    check_line("t2", 0, 12'h100, 0);

    // 3: ready held low over three lines; the third has no free buffer.
    do_reset();
    ready_mode = 0;
    send_line(12'h400, N, 0);
    idle(2);
    send_line(12'h500, N, 0);
    idle(2);
    send_line(12'h600, N, 0);
    idle(5);
    chk("t3_drop", 64'(drop_cnt), 64'(1));
    chk("t3_no_beats", 64'(data_log.size()), 64'(0));
    ready_mode = 1;
    idle(40);
    chk("t3_count", 64'(data_log.size()), 64'(2 * N));
    check_line("t3a", 0, 12'h400, 0);
    check_line("t3b", N, 12'h500, 1);

    // 4: early SI aborts a partial line.
    do_reset();
    ready_mode = 1;
    send_line(12'h2F0, 5, 0);
    send_line(12'h200, N, 0);
    idle(15);
    chk("t4_short", 64'(short_cnt), 64'(1));
    chk("t4_count", 64'(data_log.size()), 64'(N));
    check_line("t4", 0, 12'h200, 0);

    // 5: trigger coincident with the SI edge is discarded.
    do_reset();
    drive(1'b1, 1'b1, 12'h3FF, 1'b0);
    for (int i = 0; i < N; i++) drive(1'b0, 1'b1, AW'(12'h300 + i), 1'b0);
    idle(15);
    chk("t5_count", 64'(data_log.size()), 64'(N));
    check_line("t5", 0, 12'h300, 0);

    // 6: reset mid-stream, then a clean line.
    do_reset();
    send_line(12'h100, N, 0);
    begin
      int t = 0;
      while (data_log.size() < 3 && t < 40) begin
        idle(1);
        t++;
      end
      chk("t6_reach_beat3", 64'(data_log.size() >= 3), 64'(1));
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("t6_valid_after_reset", 64'(bus.m_valid), 64'(0));
    chk("t6_drop_after_reset", 64'(drop_cnt), 64'(0));
    chk("t6_short_after_reset", 64'(short_cnt), 64'(0));
    begin
      int nlast = 0;
      foreach (last_log[i]) if (last_log[i]) nlast++;
      chk("t6_no_last_seen", 64'(nlast), 64'(0));
    end
    idle(2);
    clear_logs();
    send_line(12'h700, N, 0);
    idle(15);
    chk("t6_count", 64'(data_log.size()), 64'(N));
    check_line("t6", 0, 12'h700, 0);

    // Randomized lines, stalls, short lines, held SI, coincident triggers.
    do_reset();
    for (int l = 0; l < 40; l++) begin
      int kind;
      kind       = $urandom_range(0, 9);
      ready_mode = 3;
      rdy_pct    = $urandom_range(5, 100);
      if (l == 20) do_reset();
      case (kind)
        6: begin
          rand_line($urandom_range(1, N - 1), 1);
          rand_line(N, 1);
        end
        7: begin
          drive(1'b1, 1'b1, AW'($urandom), 1'b0);
          for (int i = 0; i < N; i++) drive(1'b0, 1'b1, AW'($urandom), 1'b0);
        end
        8: idle(30);
        9: begin
          drive(1'b1, 1'b0, '0, 1'b0);
          drive(1'b1, 1'b1, AW'($urandom), 1'b0);
          drive(1'b1, 1'b1, AW'($urandom), 1'b0);
          for (int i = 0; i < N - 2; i++) drive(1'b0, 1'b1, AW'($urandom), 1'b0);
        end
        default: rand_line(N, 2);
      endcase
      repeat ($urandom_range(0, 6)) drive(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), 1'b0);
    end

    ready_mode = 1;
    begin
      int t = 0;
      while ((exp_id.size() != 0 || bus.m_valid) && t < 200) begin
        idle(1);
        t++;
      end
      chk("drain_complete", 64'(exp_id.size() == 0 && !bus.m_valid), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
